mtl2_cpu_oci_dct_ctrl: RTL and testbench
========================================

MTL2_CPU_OCI_DCT_CTRL -- requirements
Module: mtl2_cpu_oci_dct_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 7: trace-memory address width (depth 2^ADDR_W words).
REQ-002 The block SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port trace_enable  input  1  fragment acceptance enabled.
REQ-005 The block SHALL have ports itrace_valid/dtrace_valid  input  1 each  fragment offered by instruction/data trace requester.
REQ-006 The block SHALL have ports itrace_frag/dtrace_frag  input  3 each  fragment payload.
REQ-007 The block SHALL have ports itrace_ack/dtrace_ack  output  1 each  fragment accepted this cycle (combinational grant).
REQ-008 The block SHALL have port flush_req  input  1  single-cycle pulse: write out partial buffer, then signal done.
REQ-009 The block SHALL have port flush_done  output  1  one-cycle pulse when the flush completes.
REQ-010 The block SHALL have ports tw_valid  output  1, tw_ready  input  1: trace-memory write handshake.
REQ-011 The block SHALL have ports tw_addr  output  ADDR_W  and tw_data  output  34  ({dct_count, dct_buffer}).
REQ-012 The block SHALL have ports dct_buffer  output  30  and dct_count  output  4: packing buffer and fragment count (0..10).
REQ-013 The block SHALL have port wrapped  output  1: sticky, set when tw_addr wraps.

Function
REQ-014 States SHALL be COLLECT, WRITE and DONE; reset state SHALL be COLLECT.
REQ-015 In COLLECT with trace_enable=1 and dct_count<10, at most one fragment SHALL be granted per cycle; no grants in WRITE or DONE.
REQ-016 With both requesters valid, the grant SHALL go to the requester not granted last (round-robin); the pointer SHALL update only on a grant and SHALL favour itrace after reset.
REQ-017 On grant: dct_buffer <= {dct_buffer[26:0], frag} and dct_count <= dct_count+1 next cycle.
REQ-018 When a grant brings dct_count to 10, the next state SHALL be WRITE, so tw_valid rises the cycle after the 10th ack.
REQ-019 In WRITE, tw_valid SHALL be 1 and tw_data/tw_addr SHALL stay stable until the cycle tw_ready=1.
REQ-020 On tw_valid&tw_ready: buffer and count SHALL clear to 0, and tw_addr SHALL increment modulo 2^ADDR_W.
REQ-021 On that transfer, wrapped SHALL set if tw_addr was all-ones; wrapped SHALL clear only on reset.
REQ-022 A flush_req in any state SHALL set flush_pending.
REQ-023 A fragment granted in the same cycle as flush_req SHALL be included in the flushed word.
REQ-024 From COLLECT with flush_pending and dct_count>0, the next state SHALL be WRITE (partial word).
REQ-025 From COLLECT with flush_pending and dct_count=0, the next state SHALL be DONE (no write issued).
REQ-026 After a WRITE transfer, the next state SHALL be DONE if flush_pending, else COLLECT.
REQ-027 DONE SHALL last exactly one cycle, asserting flush_done=1, clearing flush_pending, and returning to COLLECT.
REQ-028 A flush_req arriving during DONE SHALL be held pending and serviced on return to COLLECT.
REQ-029 trace_enable=0 SHALL block grants only; WRITE and flush SHALL still complete.

Reset
REQ-030 While reset is high at a clock edge, all registers SHALL clear next cycle: state=COLLECT, dct_buffer=0, dct_count=0, tw_addr=0, tw_valid=0, flush_done=0, wrapped=0, flush_pending=0, rr pointer=itrace.
REQ-031 Reset asserted mid-WRITE SHALL drop tw_valid the following cycle and discard the buffered word.

Verification
REQ-032 The bench SHALL cover: itrace only, frags 1..7,0,1,2 on 10 consecutive cycles -> tw_valid next cycle, tw_data={4'd10, 30'o1234567012}, tw_addr=0.
REQ-033 The bench SHALL cover: both valid continuously for 4 cycles -> acks alternate i,d,i,d.
REQ-034 The bench SHALL cover: 3 frags, then flush_req, tw_ready=1 -> one write with count 3 (buffer low 9 bits = frags), flush_done one cycle after the transfer, count 0.
REQ-035 The bench SHALL cover: flush_req with count 0 -> no tw_valid, flush_done exactly 1 cycle later.
REQ-036 The bench SHALL cover: ADDR_W=2, 4 full words -> tw_addr 0,1,2,3 then 0, wrapped=1 after the 4th transfer.
REQ-037 The bench SHALL cover: tw_ready low 5 cycles in WRITE -> tw_valid/tw_data stable, no acks, then reset -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mtl2_cpu_oci_dct_ctrl.sv
// mtl2_cpu_oci_dct_ctrl: packs 3-bit trace fragments from two round-robin requesters into 34-bit trace-memory words
// with flush support.
module mtl2_cpu_oci_dct_ctrl #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trace_enable,
    input  logic              itrace_valid,
    input  logic              dtrace_valid,
    input  logic [2:0]        itrace_frag,
    input  logic [2:0]        dtrace_frag,
    output logic              itrace_ack,
    output logic              dtrace_ack,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              tw_valid,
    input  logic              tw_ready,
    output logic [ADDR_W-1:0] tw_addr,
    output logic [33:0]       tw_data,
    output logic [29:0]       dct_buffer,
    output logic [3:0]        dct_count,
    output logic              wrapped
);
    typedef enum logic [1:0] {COLLECT, WRITE, DONE} state_t;
    state_t state, state_nxt;
    logic pref_d, flush_pending, can_grant, grant, pend_eff, xfer;
    logic [2:0] frag;
    logic [3:0] count_nxt;

    assign tw_valid   = state == WRITE;
    assign flush_done = state == DONE;
    assign tw_data    = {dct_count, dct_buffer};

    // A flush arriving this cycle already counts, so a same-cycle fragment joins the flushed word
    always_comb begin
        can_grant  = state == COLLECT && trace_enable && dct_count < 4'd10;
        itrace_ack = can_grant && itrace_valid && (!dtrace_valid || !pref_d);
        dtrace_ack = can_grant && dtrace_valid && !itrace_ack;
        grant      = itrace_ack || dtrace_ack;
        frag       = itrace_ack ? itrace_frag : dtrace_frag;
        count_nxt  = dct_count + 4'(grant);
        pend_eff   = flush_pending || flush_req;
        xfer       = tw_valid && tw_ready;
        state_nxt  = (state == COLLECT) ?
                         ((count_nxt == 4'd10 || (pend_eff && count_nxt != 4'd0)) ? WRITE :
                          (pend_eff ? DONE : COLLECT)) :
                     (state == WRITE) ? (!xfer ? WRITE : (pend_eff ? DONE : COLLECT)) :
                     COLLECT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= COLLECT;
            dct_buffer    <= '0;
            dct_count     <= '0;
            tw_addr       <= '0;
            wrapped       <= 1'b0;
            flush_pending <= 1'b0;
            pref_d        <= 1'b0;
        end else begin
            state         <= state_nxt;
            flush_pending <= flush_req || (flush_pending && state != DONE);
            if (grant) begin
                dct_buffer <= {dct_buffer[26:0], frag};
                dct_count  <= count_nxt;
                pref_d     <= itrace_ack;
            end
            if (xfer) begin
                dct_buffer <= '0;
                dct_count  <= '0;
                tw_addr    <= tw_addr + ADDR_W'(1);
                wrapped    <= wrapped | (&tw_addr);
            end
        end
    end
endmodule

// File: tb/tb_mtl2_cpu_oci_dct_ctrl.sv
// tb_mtl2_cpu_oci_dct_ctrl: directed vector table, corner-case sequences and random traffic
// checked against a fragment-queue reference model.
module tb_mtl2_cpu_oci_dct_ctrl;
    localparam int AW = 2;
    logic clk = 1'b0;
    logic reset, trace_enable, itrace_valid, dtrace_valid, flush_req, tw_ready;
    logic [2:0] itrace_frag, dtrace_frag;
    logic itrace_ack, dtrace_ack, flush_done, tw_valid, wrapped;
    logic [AW-1:0] tw_addr;
    logic [33:0] tw_data;
    logic [29:0] dct_buffer;
    logic [3:0] dct_count;
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    mtl2_cpu_oci_dct_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .trace_enable(trace_enable),
        .itrace_valid(itrace_valid), .dtrace_valid(dtrace_valid),
        .itrace_frag(itrace_frag), .dtrace_frag(dtrace_frag),
        .itrace_ack(itrace_ack), .dtrace_ack(dtrace_ack),
        .flush_req(flush_req), .flush_done(flush_done),
        .tw_valid(tw_valid), .tw_ready(tw_ready), .tw_addr(tw_addr), .tw_data(tw_data),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .wrapped(wrapped)
    );

    // Reference model: pending fragments kept as a queue, word = fragments read as octal digits
    int q[$];
    int m_addr;
    bit m_write, m_done, m_pend, m_wrapped, m_favour_i, e_ia, e_da;
    logic s_ia, s_da, s_tv, s_fd, s_wr;
    logic [AW-1:0] s_addr;
    logic [33:0] s_data;

    function automatic logic [29:0] packq();
        logic [29:0] b = '0;
        foreach (q[k]) b = b * 30'd8 + 30'(q[k]);
        return b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, en, iv, input logic [2:0] ifr, input bit dv,
                        input logic [2:0] dfr, input bit fl, rdy);
        bit can, pend;
        reset = r; trace_enable = en; itrace_valid = iv; itrace_frag = ifr;
        dtrace_valid = dv; dtrace_frag = dfr; flush_req = fl; tw_ready = rdy;
        @(negedge clk);
        can  = !m_write && !m_done && en && q.size() < 10;
        e_ia = can && iv && (!dv || m_favour_i);
        e_da = can && dv && !e_ia;
        s_ia = itrace_ack; s_da = dtrace_ack; s_tv = tw_valid; s_fd = flush_done;
        s_wr = wrapped; s_addr = tw_addr; s_data = tw_data;
        check("ctl", 64'({itrace_ack, dtrace_ack, tw_valid, flush_done, wrapped, tw_addr}),
              64'({e_ia, e_da, m_write, m_done, m_wrapped, AW'(m_addr)}));
        check("tw_data", 64'(tw_data), 64'({4'(q.size()), packq()}));
        check("buffer", 64'({dct_count, dct_buffer}), 64'({4'(q.size()), packq()}));
        @(posedge clk);
        if (r) begin
            q.delete(); m_addr = 0; m_write = 0; m_done = 0; m_pend = 0; m_wrapped = 0; m_favour_i = 1;
        end else begin
            pend = m_pend || fl;
            if (e_ia) q.push_back(int'(ifr));
            if (e_da) q.push_back(int'(dfr));
            if (e_ia || e_da) m_favour_i = e_da;
            if (m_done) begin
                m_done = 0; m_pend = fl;
            end else if (m_write) begin
                m_pend = pend;
                if (rdy) begin
                    q.delete();
                    if (m_addr == (1 << AW) - 1) m_wrapped = 1;
                    m_addr = (m_addr + 1) % (1 << AW);
                    m_write = 0; m_done = pend;
                end
            end else begin
                m_pend = pend;
                if (q.size() == 10 || (pend && q.size() > 0)) m_write = 1;
                else if (pend) m_done = 1;
            end
        end
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(0, 1, 0, 3'd0, 0, 3'd0, 0, rdy);
    endtask

    typedef struct {
        bit rst, en, iv, dv, fl, rdy;
        logic [2:0] ifr, dfr;
        bit ia, da, tv, fd, wr;
        logic [3:0] cnt;
        logic [29:0] bufv;
        logic [AW-1:0] addr;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t v(bit rst, en, iv, logic [2:0] ifr, bit dv, logic [2:0] dfr, bit fl, rdy,
                               bit ia, da, tv, fd, logic [3:0] cnt, logic [29:0] bufv,
                               logic [AW-1:0] addr, bit wr);
        vec_t t;
        t.rst = rst; t.en = en; t.iv = iv; t.ifr = ifr; t.dv = dv; t.dfr = dfr; t.fl = fl; t.rdy = rdy;
        t.ia = ia; t.da = da; t.tv = tv; t.fd = fd; t.cnt = cnt; t.bufv = bufv; t.addr = addr; t.wr = wr;
        return t;
    endfunction

    initial begin
        logic [2:0] f[10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
        logic [29:0] pre = '0;
        logic [33:0] held;
        step(1, 0, 0, 3'd0, 0, 3'd0, 0, 0);
        step(1, 0, 0, 3'd0, 0, 3'd0, 0, 0);

        tbl.push_back(v(0,0,0,0,0,0,0,0, 0,0,0,0, 0,30'd0,0,0));
        for (int k = 0; k < 10; k++) begin
            tbl.push_back(v(0,1,1,f[k],0,0,0,0, 1,0,0,0, 4'(k),pre,0,0));
            pre = pre * 30'd8 + 30'(f[k]);
        end
        tbl.push_back(v(0,1,0,0,0,0,0,1, 0,0,1,0, 10,30'o1234567012,0,0));
        tbl.push_back(v(1,1,1,1,1,2,0,0, 0,1,0,0, 0,30'd0,1,0));
        tbl.push_back(v(0,1,1,3,1,4,0,0, 1,0,0,0, 0,30'd0,0,0));
        tbl.push_back(v(0,1,1,3,1,4,0,0, 0,1,0,0, 1,30'o3,0,0));
        tbl.push_back(v(0,1,1,3,1,4,0,0, 1,0,0,0, 2,30'o34,0,0));
        tbl.push_back(v(0,1,1,3,1,4,1,0, 0,1,0,0, 3,30'o343,0,0));
        tbl.push_back(v(0,1,1,5,0,0,0,1, 0,0,1,0, 4,30'o3434,0,0));
        tbl.push_back(v(0,1,0,0,0,0,1,0, 0,0,0,1, 0,30'd0,1,0));
        tbl.push_back(v(0,1,0,0,0,0,0,0, 0,0,0,0, 0,30'd0,1,0));
        tbl.push_back(v(0,1,0,0,0,0,0,0, 0,0,0,1, 0,30'd0,1,0));
        tbl.push_back(v(0,1,0,0,0,0,1,0, 0,0,0,0, 0,30'd0,1,0));
        tbl.push_back(v(0,1,0,0,0,0,0,0, 0,0,0,1, 0,30'd0,1,0));
        tbl.push_back(v(0,1,0,0,0,0,0,0, 0,0,0,0, 0,30'd0,1,0));
        foreach (tbl[n]) begin
            step(tbl[n].rst, tbl[n].en, tbl[n].iv, tbl[n].ifr, tbl[n].dv, tbl[n].dfr, tbl[n].fl, tbl[n].rdy);
            check($sformatf("row%0d_ctl", n), 64'({s_ia, s_da, s_tv, s_fd, s_wr, s_addr}),
                  64'({tbl[n].ia, tbl[n].da, tbl[n].tv, tbl[n].fd, tbl[n].wr, tbl[n].addr}));
            check($sformatf("row%0d_data", n), 64'(s_data), 64'({tbl[n].cnt, tbl[n].bufv}));
        end

        // Partial flush of three fragments
        step(1, 0, 0, 3'd0, 0, 3'd0, 0, 0);
        step(0, 1, 1, 3'd5, 0, 3'd0, 0, 0);
        step(0, 1, 1, 3'd6, 0, 3'd0, 0, 0);
        step(0, 1, 1, 3'd7, 0, 3'd0, 0, 0);
        step(0, 1, 0, 3'd0, 0, 3'd0, 1, 1);
        idle(1);
        check("flush_tv", 64'(s_tv), 64'd1);
        check("flush_cnt", 64'(s_data[33:30]), 64'd3);
        check("flush_frags", 64'(s_data[8:0]), 64'(9'o567));
        idle(1);
        check("flush_done", 64'({s_fd, s_data[33:30]}), 64'({1'b1, 4'd0}));
        idle(1);
        check("flush_done_1cyc", 64'(s_fd), 64'd0);

        // Address wrap with a 4-word memory
        step(1, 0, 0, 3'd0, 0, 3'd0, 0, 0);
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 10; k++) step(0, 1, 1, 3'(k + w), 0, 3'd0, 0, 0);
            idle(1);
            check($sformatf("wrap_w%0d", w), 64'({s_tv, s_wr, s_addr}), 64'({1'b1, 1'b0, AW'(w)}));
        end
        idle(0);
        check("wrap_after", 64'({s_wr, s_addr}), 64'({1'b1, AW'(0)}));

        // Stalled write, then reset mid-write
        step(1, 0, 0, 3'd0, 0, 3'd0, 0, 0);
        for (int k = 0; k < 10; k++) step(0, 1, 0, 3'd0, 1, 3'(7 - k), 0, 0);
        step(0, 1, 1, 3'd1, 1, 3'd2, 0, 0);
        held = s_data;
        check("stall_first", 64'({s_tv, s_ia, s_da}), 64'({1'b1, 1'b0, 1'b0}));
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 1, 3'd1, 1, 3'd2, 0, 0);
            check($sformatf("stall_%0d", k), 64'({s_tv, s_ia, s_da, s_data}), 64'({1'b1, 1'b0, 1'b0, held}));
        end
        step(1, 0, 0, 3'd0, 0, 3'd0, 0, 0);
        idle(0);
        check("reset_mid_write", 64'({s_tv, s_fd, s_ia, s_da, s_wr, s_addr, s_data}), 64'd0);

        // Random traffic
        step(1, 0, 0, 3'd0, 0, 3'd0, 0, 0);
        for (int n = 0; n < 4000; n++)
            step($urandom_range(199) == 0, $urandom_range(3) != 0, 1'($urandom), 3'($urandom),
                 1'($urandom), 3'($urandom), $urandom_range(24) == 0, 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
